ccff_word_loader: RTL and testbench

CCFF_WORD_LOADER -- requirements
Module: ccff_word_loader

---
 rtl/ccff_word_loader.sv | 94 +++++++++
 tb/tb_ccff_word_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ccff_word_loader.sv
// Word-parallel configuration loader: shifts WORD_W-bit words into a shadow
// register and commits the whole chain to mem_out in a single edge.
module ccff_word_loader #(
    parameter int CHAIN_LEN = 16,
    parameter int WORD_W    = 4
) (
    input  logic                 prog_clk,
    input  logic                 prog_reset,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [WORD_W-1:0]    in_data,
    output logic                 in_ready,
    output logic [CHAIN_LEN-1:0] mem_out,
    output logic [CHAIN_LEN-1:0] mem_outb,
    output logic                 busy,
    output logic                 done
);

    localparam int NWORDS = CHAIN_LEN / WORD_W;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [CHAIN_LEN-1:0] r_shadow;
    logic [CHAIN_LEN-1:0] r_mem;
    logic [CHAIN_LEN-1:0] r_memb;
    logic                 r_done;
    logic [CHAIN_LEN-1:0] w_shadow_next;

    // Single-word chains have no older bits to keep, so the slice would be empty.
    generate
        if (NWORDS > 1) begin : g_multi
            assign w_shadow_next = {r_shadow[CHAIN_LEN-WORD_W-1:0], in_data};
        end else begin : g_single
            assign w_shadow_next = in_data;
        end
    endgenerate

    // Load sequencer, shadow shift register and commit of the live configuration.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_mem    <= '0;
            r_memb   <= '1;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_SHIFT;
                        r_cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (in_valid) begin
                        r_shadow <= w_shadow_next;
                        // Counter parks on the last index instead of wrapping.
                        if (r_cnt == LAST_CNT) begin
                            r_state <= ST_COMMIT;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    r_mem   <= r_shadow;
                    r_memb  <= ~r_shadow;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready = (r_state == ST_SHIFT);
    assign busy     = (r_state == ST_SHIFT) || (r_state == ST_COMMIT);
    assign mem_out  = r_mem;
    assign mem_outb = r_memb;
    assign done     = r_done;

endmodule

// File: tb/tb_ccff_word_loader.sv
// Directed bench for ccff_word_loader at CHAIN_LEN=16, WORD_W=4.
module tb_ccff_word_loader;

    logic        prog_clk = 1'b0;
    logic        prog_reset;
    logic        start;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        in_ready;
    logic [15:0] mem_out;
    logic [15:0] mem_outb;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    ccff_word_loader #(.CHAIN_LEN(16), .WORD_W(4)) dut (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_out    (mem_out),
        .mem_outb   (mem_outb),
        .busy       (busy),
        .done       (done)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    // Drives four consecutive words, first word from the top nibble.
    task automatic drive_words(input logic [15:0] w);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = w[15-4*i -: 4];
            step();
        end
        in_valid = 1'b0;
        in_data  = 4'h0;
    endtask

    task automatic test_reset();
        prog_reset = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 4'hF;
        step();
        n_vec++; if (mem_out !== 16'h0000) begin n_err++; $display("FAIL reset_mem_out: got %h want 0000", mem_out); end
        n_vec++; if (mem_outb !== 16'hFFFF) begin n_err++; $display("FAIL reset_mem_outb: got %h want ffff", mem_outb); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        prog_reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 4'h0;
        step();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int busy_cyc = 0;
        int done_cyc = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        if (busy === 1'b1) busy_cyc++;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(i + 1);
            step();
            if (busy === 1'b1) busy_cyc++;
            if (done === 1'b1) done_cyc++;
            n_vec++; if (mem_out !== 16'h0000) begin n_err++; $display("FAIL basic_hold: got %h want 0000", mem_out); end
        end
        in_valid = 1'b0;
        step();
        if (busy === 1'b1) busy_cyc++;
        if (done === 1'b1) done_cyc++;
        n_vec++; if (mem_out !== 16'h1234) begin n_err++; $display("FAIL basic_mem_out: got %h want 1234", mem_out); end
        n_vec++; if (mem_outb !== 16'hEDCB) begin n_err++; $display("FAIL basic_mem_outb: got %h want edcb", mem_outb); end
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b want 1", done); end
        for (int i = 0; i < 3; i++) begin
            step();
            if (busy === 1'b1) busy_cyc++;
            if (done === 1'b1) done_cyc++;
        end
        n_vec++; if (busy_cyc != 5) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 5", busy_cyc); end
        n_vec++; if (done_cyc != 1) begin n_err++; $display("FAIL basic_done_cycles: got %0d want 1", done_cyc); end
    endtask

    // Loads 'w' with per-word idle gaps, checking mem_out holds 'prior' until the commit edge.
    task automatic test_hold_load(input string name, input logic [15:0] prior,
                                  input logic [15:0] w, input int g0, input int g1,
                                  input int g2, input int g3);
        int gaps[4];
        gaps = '{g0, g1, g2, g3};
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b0;
            in_data  = 4'hF;
            for (int g = 0; g < gaps[i]; g++) begin
                step();
                n_vec++; if (mem_out !== prior) begin n_err++; $display("FAIL %s_gap_hold: got %h want %h", name, mem_out, prior); end
                n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s_gap_ready: got %b want 1", name, in_ready); end
            end
            in_valid = 1'b1;
            in_data  = w[15-4*i -: 4];
            step();
            n_vec++; if (mem_out !== prior) begin n_err++; $display("FAIL %s_hold: got %h want %h", name, mem_out, prior); end
        end
        in_valid = 1'b0;
        in_data  = 4'h0;
        n_vec++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL %s_commit_state: got busy=%b ready=%b want busy=1 ready=0", name, busy, in_ready); end
        step();
        n_vec++; if (mem_out !== w) begin n_err++; $display("FAIL %s_mem_out: got %h want %h", name, mem_out, w); end
        n_vec++; if (mem_outb !== ~w) begin n_err++; $display("FAIL %s_mem_outb: got %h want %h", name, mem_outb, ~w); end
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL %s_done: got %b want 1", name, done); end
        step();
    endtask

    task automatic test_ignored();
        in_valid = 1'b1;
        in_data  = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if (in_ready !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL idle_valid_state: got ready=%b busy=%b want 0 0", in_ready, busy); end
            n_vec++; if (mem_out !== 16'h1234) begin n_err++; $display("FAIL idle_valid_mem: got %h want 1234", mem_out); end
        end
        start = 1'b1; in_valid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            start    = (i == 1 || i == 2);
            in_valid = 1'b1;
            in_data  = 4'(9 - i);
            step();
        end
        n_vec++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL start_in_shift_commit: got busy=%b ready=%b want 1 0", busy, in_ready); end
        start = 1'b1; in_data = 4'hF;
        step();
        start = 1'b0; in_valid = 1'b0;
        n_vec++; if (mem_out !== 16'h9876) begin n_err++; $display("FAIL start_in_shift_mem: got %h want 9876", mem_out); end
        step();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL start_in_commit_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_load();
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 4'hC; step();
        in_data = 4'hD; step();
        prog_reset = 1'b1;
        step();
        prog_reset = 1'b0; in_valid = 1'b0;
        n_vec++; if (mem_out !== 16'h0000) begin n_err++; $display("FAIL midrst_mem_out: got %h want 0000", mem_out); end
        n_vec++; if (mem_outb !== 16'hFFFF) begin n_err++; $display("FAIL midrst_mem_outb: got %h want ffff", mem_outb); end
        n_vec++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL midrst_state: got busy=%b ready=%b want 0 0", busy, in_ready); end
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        drive_words(16'h5678);
        step();
        n_vec++; if (mem_out !== 16'h5678) begin n_err++; $display("FAIL midrst_reload: got %h want 5678", mem_out); end
        step();
        // Reset landing in the commit cycle must cancel the pending commit.
        start = 1'b1;
        step();
        start = 1'b0;
        drive_words(16'h1234);
        prog_reset = 1'b1;
        step();
        prog_reset = 1'b0;
        n_vec++; if (mem_out !== 16'h0000 || done !== 1'b0) begin n_err++; $display("FAIL commitrst: got mem=%h done=%b want 0000 0", mem_out, done); end
        step();
        n_vec++; if (mem_out !== 16'h0000 || done !== 1'b0) begin n_err++; $display("FAIL commitrst_after: got mem=%h done=%b want 0000 0", mem_out, done); end
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        step();
        start = 1'b0;
        drive_words(16'h1234);
        step();
        n_vec++; if (mem_out !== 16'h1234 || done !== 1'b1) begin n_err++; $display("FAIL b2b_first: got mem=%h done=%b want 1234 1", mem_out, done); end
        start = 1'b1;
        step();
        start = 1'b0;
        n_vec++; if (in_ready !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL b2b_restart: got ready=%b busy=%b want 1 1", in_ready, busy); end
        drive_words(16'hABCD);
        step();
        n_vec++; if (mem_out !== 16'hABCD || done !== 1'b1) begin n_err++; $display("FAIL b2b_second: got mem=%h done=%b want abcd 1", mem_out, done); end
        step();
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_done_pulse: got %b want 0", done); end
    endtask

    initial begin
        prog_reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 4'h0;
        test_reset();
        test_basic();
        test_hold_load("reload", 16'h1234, 16'hABCD, 0, 0, 0, 0);
        test_hold_load("stall", 16'hABCD, 16'h1234, 0, 3, 1, 2);
        test_ignored();
        test_reset_mid_load();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
